// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Reads bursts of words from a FIFO with a one-cycle read latency and presents
// them downstream on a valid/ready interface through a 2-entry skid buffer.
// A burst is requested with cmd_valid/cmd_len while idle; done pulses once the
// last word of the burst has been accepted downstream (or one cycle after a
// zero-length request).
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous, active-high reset
//   cmd_valid       burst request valid (accepted only while cmd_ready=1)
//   cmd_len[7:0]    number of words in the burst
//   cmd_ready       high only while idle
//   fifo_rd_en      combinational FIFO read strobe
//   fifo_data_out   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_data          downstream data (oldest buffered word)
//   m_valid         downstream valid
//   m_ready         downstream ready
//   done            one-cycle burst-completion pulse
//   err_underflow   sticky: fifo_underflow has been seen since reset
//   rd_count[15:0]  words delivered downstream since reset
//
// Build option
//   READ_CNT_EN     when defined, rd_count is a wrapping 16-bit pop counter;
//                   otherwise rd_count is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module fifo_reader #(
   parameter int FIFO_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   input  logic [7:0]            cmd_len,
   output logic                  cmd_ready,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  done,
   output logic                  err_underflow,
   output logic [15:0]           rd_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [7:0]            remaining;
   logic                  inflight;
   logic [1:0]            buf_count;
   logic [FIFO_WIDTH-1:0] buf_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  zero_done;
   logic                  start;
   logic                  zero_cmd;
   logic                  pop;
   logic                  drain_done;
   logic [2:0]            occupancy;

   assign start      = (state == IDLE) && cmd_valid && (cmd_len != 8'd0);
   assign zero_cmd   = (state == IDLE) && cmd_valid && (cmd_len == 8'd0);

   // Outputs are forced to their reset values while rst is held so nothing
   // leaks out before the first reset edge has settled the registers.
   assign m_valid    = !rst && (buf_count != 2'd0);
   assign pop        = m_valid && m_ready;

   // Words that will occupy the skid buffer after this edge; a new read may
   // only issue if its data is guaranteed a free slot two cycles from now.
   assign occupancy  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = !rst && (state == RUN) && !fifo_empty &&
                       (remaining != 8'd0) && (occupancy < 3'd2);

   assign drain_done = (state == DRAIN) && (buf_count == 2'd0) && !inflight;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of block order.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first, so no path leaves state_next unassigned and no
      // latch is inferred.
      state_next = state;
      case (state)
         IDLE:    if (start)                                 state_next = RUN;
         RUN:     if (fifo_rd_en && (remaining == 8'd1))     state_next = DRAIN;
         DRAIN:   if (drain_done)                            state_next = IDLE;
         default:                                            state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cmd_ready = rst || (state == IDLE);
      done      = !rst && (drain_done || zero_done);
   end

   // Burst bookkeeping and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining     <= 8'd0;
         inflight      <= 1'b0;
         zero_done     <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (start)           remaining <= cmd_len;
         else if (fifo_rd_en) remaining <= remaining - 8'd1;
         inflight  <= fifo_rd_en;
         zero_done <= zero_cmd;
         if (fifo_underflow) err_underflow <= 1'b1;
      end
   end

   // Skid buffer pointers and occupancy; a write and a pop in the same cycle
   // cancel in buf_count while both pointers advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_count <= 2'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
      end else begin
         if (inflight) wr_ptr <= ~wr_ptr;
         if (pop)      rd_ptr <= ~rd_ptr;
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   // NOTE: the data storage has no reset; its contents are only observed
   // through m_valid, which is qualified by buf_count.
   always_ff @(posedge clk) begin
      if (inflight) buf_mem[wr_ptr] <= fifo_data_out;
   end

   assign m_data = buf_mem[rd_ptr];

`ifdef READ_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)      rd_count <= 16'd0;
      else if (pop) rd_count <= rd_count + 16'd1;
   end
`else
   assign rd_count = 16'd0;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 FIFO_WIDTH, 16, data word width in bits; it SHALL match the attached FIFO.
REQ-002 clk  input  1  single clock; all logic SHALL sample on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 cmd_valid  input  1  burst request valid.
REQ-005 cmd_len  input  8  number of words to read in the burst.
REQ-006 cmd_ready  output  1  high only in IDLE.
REQ-007 fifo_rd_en  output  1  read strobe to FIFO; combinational.
REQ-008 fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
REQ-009 fifo_empty  input  1  FIFO empty flag.
REQ-010 fifo_underflow  input  1  FIFO underflow flag.
REQ-011 m_data  output  FIFO_WIDTH  downstream data; head of the skid buffer.
REQ-012 m_valid  output  1  downstream valid.
REQ-013 m_ready  input  1  downstream ready.
REQ-014 done  output  1  one-cycle pulse at burst completion.
REQ-015 err_underflow  output  1  sticky underflow-seen flag.
REQ-016 rd_count  output  16  total words delivered downstream.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-018 IDLE with cmd_valid=1 and cmd_len!=0: latch remaining=cmd_len and go to RUN next cycle.
REQ-019 IDLE with cmd_valid=1 and cmd_len=0: stay in IDLE and pulse done for one cycle on the next cycle.
REQ-020 fifo_rd_en SHALL equal (state==RUN) && !fifo_empty && remaining!=0 && (buf_count + inflight - pop) < 2, where pop = m_valid && m_ready.
REQ-021 fifo_rd_en SHALL never assert while fifo_empty=1 or outside RUN.
REQ-022 Each fifo_rd_en SHALL decrement remaining by 1 (8-bit, no wrap below 0).
REQ-023 When the final read issues (remaining 1 -> 0), the FSM SHALL go to DRAIN next cycle.
REQ-024 inflight SHALL be fifo_rd_en registered one cycle.
REQ-025 When inflight=1, fifo_data_out SHALL be written into the 2-entry skid buffer at that clock edge.
REQ-026 m_valid SHALL equal (buf_count!=0); m_data SHALL be the oldest buffered word; pop SHALL remove it.
REQ-027 A buffer write and a pop in the same cycle SHALL both take effect; buf_count SHALL then be unchanged.
REQ-028 Latency SHALL be 2 cycles: fifo_rd_en at cycle t gives m_valid at cycle t+2.
REQ-029 With m_ready=1 held and the FIFO never empty, throughput SHALL be one word per cycle.
REQ-030 Word order downstream SHALL equal FIFO read order; no word SHALL be dropped or duplicated.
REQ-031 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-032 The FSM SHALL leave DRAIN for IDLE when buf_count=0 and inflight=0, pulsing done that same cycle transition (done high for one cycle).
REQ-033 cmd_valid outside IDLE SHALL be ignored.
REQ-034 err_underflow SHALL be set when fifo_underflow=1 is sampled and SHALL clear only on reset.

Reset
REQ-035 rst=1 at a clock edge SHALL force state=IDLE, remaining=0, inflight=0, buf_count=0, done=0, err_underflow=0, rd_count=0.
REQ-036 During and after reset, m_valid=0, fifo_rd_en=0 and cmd_ready=1; m_data is don't-care.
REQ-037 Reset mid-burst SHALL discard buffered and in-flight words, with no done pulse.

Configuration
REQ-038 With READ_CNT_EN defined, rd_count SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-039 Without READ_CNT_EN, rd_count SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-040 FIFO holds 5 words; cmd_len=4; m_ready=1 -> 4 consecutive fifo_rd_en, words 1-4 on m_data at cycles t+2..t+5, done one cycle later, and 1 word left in the FIFO.
REQ-041 cmd_len=3 with m_ready=0 for 10 cycles -> exactly 2 reads issue, m_data stays stable, and the 3rd read issues on the first pop.
REQ-042 FIFO empty mid-burst (cmd_len=6, 2 words available) -> fifo_rd_en stays low while empty, the burst resumes on a refill, and err_underflow stays 0.
REQ-043 fifo_underflow forced high for 1 cycle -> err_underflow=1 until rst.
REQ-044 rst asserted in RUN with 2 words buffered -> next cycle m_valid=0, state IDLE, cmd_ready=1, and no done pulse.
REQ-045 READ_CNT_EN defined, 3 bursts of 7 words -> rd_count=21; build without the macro -> rd_count=0.
